// File: rtl/demux_1x2_reg.sv
// Registered 1-to-2 valid/ready demultiplexer with a main entry plus a skid entry.
// Optional packet lock (route held from first to last beat) under DEMUX_1X2_LOCK_EN.
module demux_1x2_reg #(
  parameter int width = 31
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [width:0]   s_data,
  input  logic             s_sel,
  input  logic             s_last,
  output logic             m0_valid,
  input  logic             m0_ready,
  output logic [width:0]   m0_data,
  output logic             m0_last,
  output logic             m1_valid,
  input  logic             m1_ready,
  output logic [width:0]   m1_data,
  output logic             m1_last
);

  logic             main_valid, main_sel, main_last;
  logic [width:0]   main_data;
  logic             skid_valid, skid_sel, skid_last;
  logic [width:0]   skid_data;

  logic             main_valid_n, main_sel_n, main_last_n;
  logic [width:0]   main_data_n;
  logic             skid_valid_n, skid_sel_n, skid_last_n;
  logic [width:0]   skid_data_n;

  logic             accept;
  logic             pop;
  logic             route_sel;

  assign accept = s_valid && s_ready;
  assign pop    = main_valid && (main_sel ? m1_ready : m0_ready);

`ifdef DEMUX_1X2_LOCK_EN
  // Packet lock: the first beat of a multi-beat packet fixes the route until its last beat.
  typedef enum logic {IDLE, LOCKED} lock_state_t;

  lock_state_t lock_state, lock_state_n;
  logic        route, route_n;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      lock_state <= IDLE;
      route      <= 1'b0;
    end else begin
      lock_state <= lock_state_n;
      route      <= route_n;
    end
  end

  always_comb begin
    lock_state_n = lock_state;
    route_n      = route;
    route_sel    = (lock_state == LOCKED) ? route : s_sel;
    if (accept) begin
      case (lock_state)
        IDLE: begin
          if (!s_last) begin
            route_n      = s_sel;
            lock_state_n = LOCKED;
          end
        end
        LOCKED: begin
          if (s_last) begin
            lock_state_n = IDLE;
          end
        end
        default: lock_state_n = IDLE;
      endcase
    end
  end
`else
  assign route_sel = s_sel;
`endif

  // The skid only fills when main is stalled, and s_ready guarantees it never overflows.
  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    main_sel_n   = main_sel;
    main_last_n  = main_last;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    skid_sel_n   = skid_sel;
    skid_last_n  = skid_last;

    if (!main_valid || pop) begin
      if (skid_valid) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
        main_sel_n   = skid_sel;
        main_last_n  = skid_last;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        main_valid_n = 1'b1;
        main_data_n  = s_data;
        main_sel_n   = route_sel;
        main_last_n  = s_last;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept) begin
      skid_valid_n = 1'b1;
      skid_data_n  = s_data;
      skid_sel_n   = route_sel;
      skid_last_n  = s_last;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_sel   <= 1'b0;
      main_last  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= 1'b0;
      skid_last  <= 1'b0;
      s_ready    <= 1'b1;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      main_sel   <= main_sel_n;
      main_last  <= main_last_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      skid_sel   <= skid_sel_n;
      skid_last  <= skid_last_n;
      s_ready    <= !skid_valid_n;
    end
  end

  assign m0_valid = main_valid && !main_sel;
  assign m1_valid = main_valid &&  main_sel;
  assign m0_data  = main_data;
  assign m1_data  = main_data;
  assign m0_last  = main_last;
  assign m1_last  = main_last;

endmodule

// File: tb/tb_demux_1x2_reg.sv
// Self-checking bench for demux_1x2_reg: directed vector table, hand sequences,
// and randomized traffic against a two-deep FIFO reference model.
module tb_demux_1x2_reg;

  logic        clock;
  logic        ARESETN;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        s_sel, s_last;
  logic        m0_valid, m0_ready, m0_last;
  logic [31:0] m0_data;
  logic        m1_valid, m1_ready, m1_last;
  logic [31:0] m1_data;

  int nChecks = 0;
  int nFails  = 0;

  demux_1x2_reg #(.width(31)) dut (
    .ACLK     (clock),
    .ARESETN  (ARESETN),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_sel    (s_sel),
    .s_last   (s_last),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .m0_data  (m0_data),
    .m0_last  (m0_last),
    .m1_valid (m1_valid),
    .m1_ready (m1_ready),
    .m1_data  (m1_data),
    .m1_last  (m1_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: an ordered list of held beats, at most two deep.
  typedef struct {
    logic [31:0] data;
    logic        sel;
    logic        last;
  } beat_t;

  beat_t q[$];
  bit    mLocked = 1'b0;
  bit    mRoute  = 1'b0;

  typedef struct {
    logic        v;
    logic [31:0] data;
    logic        sel;
    logic        last;
    logic        r0;
    logic        r1;
    logic [1:0]  expValid;
    logic [31:0] expData;
    logic        expReady;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mLocked = 1'b0;
    mRoute  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and settle.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic sel,
                               input logic last, input logic r0, input logic r1);
    bit    canAccept, doPop, effSel;
    beat_t b;
    s_valid  = v;
    s_data   = d;
    s_sel    = sel;
    s_last   = last;
    m0_ready = r0;
    m1_ready = r1;
    @(posedge clock);
    canAccept = (q.size() < 2) && v;
    doPop     = (q.size() > 0) && (q[0].sel ? r1 : r0);
    effSel    = sel;
`ifdef DEMUX_1X2_LOCK_EN
    if (canAccept) begin
      if (mLocked) begin
        effSel = mRoute;
        if (last) mLocked = 1'b0;
      end else if (!last) begin
        mLocked = 1'b1;
        mRoute  = sel;
      end
    end
`endif
    if (doPop) void'(q.pop_front());
    if (canAccept) begin
      b.data = d;
      b.sel  = effSel;
      b.last = last;
      q.push_back(b);
    end
    #1;
  endtask

  task automatic checkModel(input string tag);
    logic [1:0] expV;
    expV = 2'b00;
    if (q.size() > 0) expV = q[0].sel ? 2'b10 : 2'b01;
    checkOutput({tag, " valid"}, {30'd0, m1_valid, m0_valid}, {30'd0, expV});
    checkOutput({tag, " s_ready"}, {31'd0, s_ready}, {31'd0, (q.size() < 2)});
    if (q.size() > 0) begin
      checkOutput({tag, " data"}, q[0].sel ? m1_data : m0_data, q[0].data);
      checkOutput({tag, " last"}, {31'd0, q[0].sel ? m1_last : m0_last}, {31'd0, q[0].last});
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 32'hA5A5A5A5, 1'b1};
    vecs[1] = '{1'b1, 32'h0000BEEF, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 32'h0000BEEF, 1'b1};
    vecs[2] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0,        1'b1};
    vecs[3] = '{1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 32'h11111111, 1'b1};
    vecs[4] = '{1'b1, 32'h22222222, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 32'h11111111, 1'b0};
    vecs[5] = '{1'b1, 32'h33333333, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 32'h11111111, 1'b0};
    vecs[6] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 32'h22222222, 1'b1};
    vecs[7] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0,        1'b1};
    vecs[8] = '{1'b1, 32'h33333333, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 32'h33333333, 1'b1};
    vecs[9] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0,        1'b1};

    ARESETN  = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_sel    = 1'b0;
    s_last   = 1'b0;
    m0_ready = 1'b1;
    m1_ready = 1'b1;
    modelReset();
    repeat (2) @(posedge clock);
    #2;
    checkOutput("reset valid", {30'd0, m1_valid, m0_valid}, 32'd0);
    checkOutput("reset s_ready", {31'd0, s_ready}, 32'd1);
    checkOutput("reset data", m0_data, 32'd0);
    ARESETN = 1'b1;

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("first edge valid", {30'd0, m1_valid, m0_valid}, 32'd0);
    checkOutput("first edge s_ready", {31'd0, s_ready}, 32'd1);

    $display("[TB] Directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].v, vecs[i].data, vecs[i].sel, vecs[i].last, vecs[i].r0, vecs[i].r1);
      checkOutput($sformatf("vec%0d valid", i), {30'd0, m1_valid, m0_valid}, {30'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d s_ready", i), {31'd0, s_ready}, {31'd0, vecs[i].expReady});
      if (vecs[i].expValid != 2'b00)
        checkOutput($sformatf("vec%0d data", i), vecs[i].expValid[1] ? m1_data : m0_data, vecs[i].expData);
    end

    $display("[TB] Alternating sel at full rate");
    for (int i = 0; i < 8; i++) begin
      logic odd;
      odd = i[0];
      applyStimulus(1'b1, 32'hC0000000 + i, odd, 1'b1, 1'b1, 1'b1);
      checkOutput($sformatf("toggle%0d valid", i), {30'd0, m1_valid, m0_valid}, odd ? 32'd2 : 32'd1);
      checkOutput($sformatf("toggle%0d data", i), odd ? m1_data : m0_data, 32'hC0000000 + i);
      checkOutput($sformatf("toggle%0d s_ready", i), {31'd0, s_ready}, 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("toggle drain valid", {30'd0, m1_valid, m0_valid}, 32'd0);

    $display("[TB] Reset with main and skid full");
    applyStimulus(1'b1, 32'hDEAD0001, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hDEAD0002, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("full s_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("full head", m0_data, 32'hDEAD0001);
    s_valid = 1'b0;
    #2;
    ARESETN = 1'b0;
    #1;
    checkOutput("midreset valid", {30'd0, m1_valid, m0_valid}, 32'd0);
    checkOutput("midreset s_ready", {31'd0, s_ready}, 32'd1);
    modelReset();
    #1;
    ARESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput($sformatf("postreset%0d valid", i), {30'd0, m1_valid, m0_valid}, 32'd0);
    end

`ifdef DEMUX_1X2_LOCK_EN
    $display("[TB] Packet lock");
    applyStimulus(1'b1, 32'h10C00001, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("lock beat0 valid", {30'd0, m1_valid, m0_valid}, 32'd2);
    applyStimulus(1'b1, 32'h10C00002, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("lock beat1 valid", {30'd0, m1_valid, m0_valid}, 32'd2);
    checkOutput("lock beat1 data", m1_data, 32'h10C00002);
    applyStimulus(1'b1, 32'h10C00003, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("lock beat2 valid", {30'd0, m1_valid, m0_valid}, 32'd2);
    checkOutput("lock beat2 last", {31'd0, m1_last}, 32'd1);
    applyStimulus(1'b1, 32'h10C00004, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("unlock beat valid", {30'd0, m1_valid, m0_valid}, 32'd1);
    checkOutput("unlock beat data", m0_data, 32'h10C00004);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
`endif

    $display("[TB] Randomized traffic against reference model");
    for (int i = 0; i < 500; i++) begin
      logic v, r0, r1, sel, last;
      v    = ($urandom_range(0, 3) != 0);
      r0   = ($urandom_range(0, 3) != 0);
      r1   = ($urandom_range(0, 2) != 0);
      sel  = $urandom_range(0, 1) != 0;
      last = ($urandom_range(0, 2) == 0);
      applyStimulus(v, $urandom, sel, last, r0, r1);
      checkModel($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
